// File: rtl/pipe_stage_chain_pkg.sv
// Shared constants and types for the elastic pipeline register chain.
// The NOP payload is the RISC-V canonical "addi x0, x0, 0".
package Pipe_Buf_Reg_PKG;

    localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;
    localparam int          MAX_STAGES = 32;

    typedef struct packed {
        logic [MAX_STAGES-1:0] stall;
        logic [MAX_STAGES-1:0] flush;
    } pipe_ctrl_t;

endpackage

// File: rtl/pipe_stage_chain_if.sv
// Producer/consumer handshake bundle of the pipeline chain.
// The chain itself sits on the slave side; the environment drives the master side.
interface pipe_stage_chain_if #(
    parameter int DATA_W = 32
) ();

    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              out_ready;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );

endinterface

// File: rtl/pipe_stage_chain_slot.sv
// One stage register of the chain: a payload plus its valid bit.
// Priority is flush > load > drain-to-bubble > hold.
module pipe_slot
    import Pipe_Buf_Reg_PKG::*;
#(
    parameter int                DATA_W = 32,
    parameter logic [DATA_W-1:0] NOP_D  = DATA_W'(NOP_INSTR)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              drain,
    input  logic              flush,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout,
    output logic              vout
);

    // A drained stage that is not refilled turns into a NOP bubble.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vout <= 1'b0;
            dout <= NOP_D;
        end else if (flush) begin
            vout <= 1'b0;
            dout <= NOP_D;
        end else if (load) begin
            vout <= 1'b1;
            dout <= din;
        end else if (drain) begin
            vout <= 1'b0;
            dout <= NOP_D;
        end
    end

endmodule

// File: rtl/pipe_stage_chain.sv
// Elastic N-stage pipeline register chain with per-stage stall/flush,
// consumer back-pressure and saturating retire/bubble counters.
module pipe_stage_chain
    import Pipe_Buf_Reg_PKG::*;
#(
    parameter int          STAGES  = 4,
    parameter int          DATA_W  = 32,
    parameter int          CNT_W   = 16,
    parameter logic [31:0] NOP_VAL = NOP_INSTR
) (
    input  logic                     clk,
    input  logic                     reset,
    pipe_stage_chain_if.slave        bus,
    input  logic [STAGES-1:0]        stall_req,
    input  logic [STAGES-1:0]        flush_mask,
    output logic [STAGES-1:0]        stage_valid,
    output logic [STAGES*DATA_W-1:0] stage_data,
    output logic [CNT_W-1:0]         retire_cnt,
    output logic [CNT_W-1:0]         bubble_cnt
);

    localparam logic [DATA_W-1:0] NOP_D = DATA_W'(NOP_VAL);

    logic [STAGES-1:0] v;
    logic [DATA_W-1:0] d   [STAGES];
    logic [DATA_W-1:0] din [STAGES];
    logic [STAGES:0]   ready;
    logic [STAGES-1:0] move;
    logic [STAGES-1:0] load;
    logic              retire_ev;
    logic              bubble_ev;

    // Readiness ripples from the consumer back to stage 0 within the cycle;
    // a stage can accept when it is empty or its payload leaves this cycle.
    always_comb begin
        ready         = '0;
        move          = '0;
        ready[STAGES] = bus.out_ready;
        for (int i = STAGES - 1; i >= 0; i--) begin
            move[i]  = v[i] & ~stall_req[i] & ready[i+1];
            ready[i] = ~v[i] | move[i];
        end
    end

    assign load = {move[STAGES-2:0], bus.in_valid & ready[0]};

    for (genvar g = 0; g < STAGES; g++) begin : g_slot
        if (g == 0) begin : g_first
            assign din[g] = bus.in_data;
        end else begin : g_rest
            assign din[g] = d[g-1];
        end

        pipe_slot #(
            .DATA_W (DATA_W),
            .NOP_D  (NOP_D)
        ) u_slot (
            .clk   (clk),
            .reset (reset),
            .load  (load[g]),
            .drain (move[g]),
            .flush (flush_mask[g]),
            .din   (din[g]),
            .dout  (d[g]),
            .vout  (v[g])
        );

        assign stage_data[g*DATA_W +: DATA_W] = d[g];
    end

    assign stage_valid   = v;
    assign bus.in_ready  = ready[0];
    assign bus.out_valid = v[STAGES-1] & ~stall_req[STAGES-1];
    assign bus.out_data  = d[STAGES-1];

    assign retire_ev = bus.out_valid & bus.out_ready;
    assign bubble_ev = bus.out_ready & ~v[STAGES-1];

    // Both counters stick at all-ones instead of wrapping.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            retire_cnt <= '0;
            bubble_cnt <= '0;
        end else begin
            if (retire_ev && retire_cnt != '1)
                retire_cnt <= retire_cnt + CNT_W'(1);
            if (bubble_ev && bubble_cnt != '1)
                bubble_cnt <= bubble_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipe_stage_chain.sv
// Directed and random checks of pipe_stage_chain against a behavioural model,
// with a second 2-bit-counter instance to exercise counter saturation.
module tb_pipe_stage_chain;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic         clk;
    logic         reset;
    logic [3:0]   stall_req;
    logic [3:0]   flush_mask;
    logic [3:0]   stage_valid,   s_stage_valid;
    logic [127:0] stage_data,    s_stage_data;
    logic [15:0]  retire_cnt,    bubble_cnt;
    logic [1:0]   s_retire_cnt,  s_bubble_cnt;

    int total = 0;
    int bad   = 0;

    // Behavioural model state: occupancy and payload per stage, event counts.
    logic        mv [4];
    logic [31:0] md [4];
    int          m_ret;
    int          m_bub;
    logic        m_ready [5];
    logic        m_leave [4];

    pipe_stage_chain_if #(.DATA_W(32)) bus   ();
    pipe_stage_chain_if #(.DATA_W(32)) bus_s ();

    assign bus_s.in_valid  = bus.in_valid;
    assign bus_s.in_data   = bus.in_data;
    assign bus_s.out_ready = bus.out_ready;

    pipe_stage_chain #(.STAGES(4), .DATA_W(32), .CNT_W(16)) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus),
        .stall_req   (stall_req),
        .flush_mask  (flush_mask),
        .stage_valid (stage_valid),
        .stage_data  (stage_data),
        .retire_cnt  (retire_cnt),
        .bubble_cnt  (bubble_cnt)
    );

    pipe_stage_chain #(.STAGES(4), .DATA_W(32), .CNT_W(2)) dut_small (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus_s),
        .stall_req   (stall_req),
        .flush_mask  (flush_mask),
        .stage_valid (s_stage_valid),
        .stage_data  (s_stage_data),
        .retire_cnt  (s_retire_cnt),
        .bubble_cnt  (s_bubble_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            mv[i] = 1'b0;
            md[i] = NOP;
        end
        m_ret = 0;
        m_bub = 0;
    endtask

    // A stage can take a payload if it is empty or its own payload is leaving.
    task automatic model_ready();
        m_ready[4] = bus.out_ready;
        for (int i = 3; i >= 0; i--) begin
            m_leave[i] = mv[i] && !stall_req[i] && m_ready[i+1];
            m_ready[i] = !mv[i] || m_leave[i];
        end
    endtask

    task automatic model_step();
        logic        nv [4];
        logic [31:0] nd [4];
        logic        arrive;
        logic [31:0] arrive_d;
        model_ready();
        if (bus.out_ready && mv[3] && !stall_req[3]) m_ret++;
        if (bus.out_ready && !mv[3]) m_bub++;
        for (int i = 0; i < 4; i++) begin
            arrive   = (i == 0) ? (bus.in_valid && m_ready[0]) : m_leave[i-1];
            arrive_d = (i == 0) ? bus.in_data : md[i-1];
            if (flush_mask[i])  begin nv[i] = 1'b0; nd[i] = NOP;      end
            else if (arrive)    begin nv[i] = 1'b1; nd[i] = arrive_d; end
            else if (m_leave[i]) begin nv[i] = 1'b0; nd[i] = NOP;     end
            else                begin nv[i] = mv[i]; nd[i] = md[i];   end
        end
        for (int i = 0; i < 4; i++) begin
            mv[i] = nv[i];
            md[i] = nd[i];
        end
    endtask

    task automatic check_output(input string tag, input bit comb_phase);
        logic [3:0]   ev;
        logic [127:0] ed;
        for (int i = 0; i < 4; i++) begin
            ev[i]          = mv[i];
            ed[i*32 +: 32] = md[i];
        end
        if (comb_phase) begin
            model_ready();
            check({tag, ".in_ready"},    128'(bus.in_ready),    128'(m_ready[0]));
            check({tag, ".out_valid"},   128'(bus.out_valid),   128'(mv[3] && !stall_req[3]));
            check({tag, ".s_in_ready"},  128'(bus_s.in_ready),  128'(m_ready[0]));
            check({tag, ".s_out_valid"}, 128'(bus_s.out_valid), 128'(mv[3] && !stall_req[3]));
        end else begin
            check({tag, ".stage_valid"}, 128'(stage_valid),   128'(ev));
            check({tag, ".stage_data"},  stage_data,          ed);
            check({tag, ".out_data"},    128'(bus.out_data),  128'(md[3]));
            check({tag, ".retire_cnt"},  128'(retire_cnt),    128'(m_ret > 65535 ? 65535 : m_ret));
            check({tag, ".bubble_cnt"},  128'(bubble_cnt),    128'(m_bub > 65535 ? 65535 : m_bub));
            check({tag, ".s_valid"},     128'(s_stage_valid), 128'(ev));
            check({tag, ".s_data"},      s_stage_data,        ed);
            check({tag, ".s_out_data"},  128'(bus_s.out_data), 128'(md[3]));
            check({tag, ".s_retire"},    128'(s_retire_cnt),  128'(m_ret > 3 ? 3 : m_ret));
            check({tag, ".s_bubble"},    128'(s_bubble_cnt),  128'(m_bub > 3 ? 3 : m_bub));
        end
    endtask

    // Drive one cycle's inputs, check the combinational outputs, clock once, check state.
    task automatic apply_stimulus(input string tag, input logic iv, input logic [31:0] id,
                                  input logic [3:0] st, input logic [3:0] fl, input logic ordy);
        bus.in_valid  = iv;
        bus.in_data   = id;
        stall_req     = st;
        flush_mask    = fl;
        bus.out_ready = ordy;
        #1;
        check_output(tag, 1'b1);
        model_step();
        @(posedge clk);
        #1;
        check_output(tag, 1'b0);
    endtask

    initial begin
        reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        stall_req     = '0;
        flush_mask    = '0;
        model_reset();

        // Reset state
        #2 reset = 1'b0;
        #1;
        check_output("reset", 1'b0);
        check_output("reset", 1'b1);
        check("reset.stage_data_const", stage_data, {4{NOP}});
        #19 reset = 1'b1;
        apply_stimulus("idle", 1'b0, 32'h0, 4'b0, 4'b0, 1'b0);
        check("idle.in_ready_const", 128'(bus.in_ready), 128'(1'b1));

        // Streaming A0..A7, first accept with consumer not yet ready
        apply_stimulus("stream0", 1'b1, 32'hA0, 4'b0, 4'b0, 1'b0);
        for (int k = 1; k < 8; k++) begin
            apply_stimulus("stream", 1'b1, 32'hA0 + 32'(k), 4'b0, 4'b0, 1'b1);
            if (k == 3) begin
                check("stream.first_out_data", 128'(bus.out_data), 128'(32'hA0));
                check("stream.first_out_valid", 128'(bus.out_valid), 128'(1'b1));
            end
        end
        for (int k = 0; k < 4; k++)
            apply_stimulus("drain", 1'b0, 32'h0, 4'b0, 4'b0, 1'b1);
        check("stream.retire_const", 128'(retire_cnt), 128'(16'd8));
        check("stream.bubble_const", 128'(bubble_cnt), 128'(16'd3));
        check("stream.s_retire_sat", 128'(s_retire_cnt), 128'(2'd3));

        // Fill chain with A0..A3 under back-pressure
        for (int k = 0; k < 4; k++)
            apply_stimulus("fill", 1'b1, 32'hA0 + 32'(k), 4'b0, 4'b0, 1'b0);

        // Load-use stall on stage 1
        apply_stimulus("stall", 1'b1, 32'hC0, 4'b0010, 4'b0, 1'b1);
        check("stall.valid_const", 128'(stage_valid), 128'(4'b1011));
        check("stall.stage0_hold", 128'(stage_data[31:0]), 128'(32'hA3));
        check("stall.stage2_nop", 128'(stage_data[95:64]), 128'(NOP));

        // Refill and hold under back-pressure for 6 cycles
        apply_stimulus("refill", 1'b1, 32'hC0, 4'b0, 4'b0, 1'b0);
        for (int k = 0; k < 6; k++)
            apply_stimulus("bp", 1'b1, 32'hC1, 4'b0, 4'b0, 1'b0);
        check("bp.in_ready_const", 128'(bus.in_ready), 128'(1'b0));

        // Branch flush of stages 0-1 while B0 is offered
        bus.in_valid = 1'b1;
        bus.out_ready = 1'b1;
        #1;
        check("flush.b0_accepted", 128'(bus.in_ready), 128'(1'b1));
        apply_stimulus("flush", 1'b1, 32'hB0, 4'b0, 4'b0011, 1'b1);
        check("flush.valid_const", 128'(stage_valid), 128'(4'b1100));
        check("flush.low_nop", stage_data[63:0], 128'({NOP, NOP}));

        // Asynchronous reset between edges with valid data
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        reset = 1'b0;
        #1;
        model_reset();
        check("midreset.out_valid_const", 128'(bus.out_valid), 128'(1'b0));
        check_output("midreset", 1'b0);
        check_output("midreset", 1'b1);
        #3 reset = 1'b1;
        apply_stimulus("postreset", 1'b0, 32'h0, 4'b0, 4'b0, 1'b0);

        // Random traffic
        for (int k = 0; k < 400; k++) begin
            logic [3:0] st;
            logic [3:0] fl;
            for (int b = 0; b < 4; b++) begin
                st[b] = ($urandom_range(7) == 0);
                fl[b] = ($urandom_range(15) == 0);
            end
            apply_stimulus("rand", ($urandom_range(3) != 0), $urandom, st, fl,
                           ($urandom_range(3) != 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipe_stage_chain.md
# pipe_stage_chain

Parametrised, elastic N-stage pipeline register chain carrying an opaque payload (instruction plus control bundle), with a valid bit per stage. It has per-stage stall and flush, bubble (NOP) injection, back-pressure from the consumer, and retire/bubble performance counters. It generalises the fixed IF/ID, ID/EX, EX/MEM and MEM/WB register set of the core: hazard detection, branch resolution and the halt logic now drive `stall_req` / `flush_mask` instead of hand-coded per-register conditions.

## Interface
- `STAGES`, 4: number of register stages (≥2)
- `DATA_W`, 32: payload width per stage
- `CNT_W`, 16: performance counter width
- `NOP_VAL`, 32'h0000_0013: payload loaded into a bubble or flushed stage (zero-extended or truncated to `DATA_W`)

- `clk`  in  1  clock; all state updates on the rising edge
- `reset`  in  1  asynchronous, active-low reset
- `in_valid`  in  1  producer offers a payload to stage 0
- `in_data`  in  DATA_W  payload offered to stage 0
- `in_ready`  out  1  stage 0 can accept this cycle
- `stall_req`  in  STAGES  bit i: stage i must not hand its payload on this cycle
- `flush_mask`  in  STAGES  bit i: kill stage i's content at this edge
- `out_ready`  in  1  consumer accepts the last stage's payload
- `out_valid`  out  1  last stage holds a valid payload that is not stalled
- `out_data`  out  DATA_W  last stage payload
- `stage_valid`  out  STAGES  valid bit of every stage
- `stage_data`  out  STAGES*DATA_W  payload of every stage; stage i occupies bits [i*DATA_W +: DATA_W]
- `retire_cnt`  out  CNT_W  count of payloads accepted by the consumer, saturating
- `bubble_cnt`  out  CNT_W  count of cycles with `out_ready`=1 and last stage invalid, saturating

## Operation
- Per stage i: `v[i]`, `d[i]`. Define `ready[STAGES]` = `out_ready`.
- `move[i]` = `v[i]` & !`stall_req[i]` & `ready[i+1]`. `ready[i]` = !`v[i]` | `move[i]`. The chain is combinational from the last stage back to stage 0.
- `in_ready` = `ready[0]`. `out_valid` = `v[STAGES-1]` & !`stall_req[STAGES-1]`. `out_data` = `d[STAGES-1]`.
- Stage 0 loads when `in_valid` & `ready[0]`. Stage i>0 loads from stage i-1 when `move[i-1]`.
- If a stage moves out and nothing is loaded into it, it becomes a bubble: `v`=0, `d`=`NOP_VAL`.
- If a stage neither moves out nor is loaded, it holds `v` and `d`.
- A stalled stage i with valid stage i+1 ready downstream: stage i+1 receives a bubble, matching the old NOP-on-hazard behaviour.
- Flush has top priority. `flush_mask[i]`=1 forces `v[i]`=0 and `d[i]`=`NOP_VAL` at the edge, regardless of hold or load.
  - Handshakes into the flushed stage still complete, so the upstream stage or producer treats the payload as consumed and it is discarded.
  - The flushed stage's own outgoing move, if any, also completes.
- `retire_cnt` += 1 when `out_valid` & `out_ready`. `bubble_cnt` += 1 when `out_ready` & !`v[STAGES-1]`. Both saturate at all-ones.
- Reset, including mid-operation, asynchronously clears every `v`, sets every `d` to `NOP_VAL`, and clears both counters. All outputs derive from these values: `in_ready`=1, `out_valid`=0, `out_data`=`NOP_VAL`.

## Timing
- Latency with no stall or back-pressure: a payload accepted at edge k appears at stage STAGES-1 after edge k+STAGES-1 (`out_valid` in that cycle). Throughput is 1 per cycle.
- Stalls propagate backwards in the same cycle; there is no skid buffer. A full chain with `out_ready`=0 drops `in_ready` combinationally.
- Control inputs are sampled at the edge they are presented. Stall/flush take effect on the edge that closes the cycle in which they are asserted.
- Simultaneous stall and flush on the same stage: flush wins, and the stage is empty after the edge.
- Counters update on the same edge as the event; there is no further latency.

## Structure
- The `NOP_INSTR` constant (32'h0000_0013) and a `pipe_ctrl_t` struct typedef (`stall`, `flush` vectors) go into `Pipe_Buf_Reg_PKG`. `NOP_VAL` defaults to `NOP_INSTR`.
- Sub-module `pipe_slot`: a single stage register with ports `load`, `drain`, `flush`, `din`, `dout`, `vout`. It owns the priority flush > load > drain-to-bubble > hold. It is instantiated `STAGES` times by a generate loop.
- The ready chain and the counters stay in the top level.

## Test plan
All scenarios use STAGES=4, DATA_W=32.
- **Reset:** after reset release, `stage_valid`=4'b0000, every `stage_data`=32'h13, `in_ready`=1, counters 0.
- **Streaming:** push 32'hA0..A7 on consecutive cycles with `out_ready`=1. Required: `out_data`=32'hA0 with `out_valid`=1 starting 3 cycles after the first accept, then one value per cycle. `retire_cnt`=8 and `bubble_cnt`=3 at the end.
- **Load-use style stall:** `stall_req`=4'b0010 for one cycle with all stages valid (A3..A0). Required: stage 1 holds, stage 2 becomes a bubble (`stage_valid`=4'b1011 after the edge), and stage 0 holds because `in_ready`=0.
- **Branch flush:** `flush_mask`=4'b0011 while 32'hB0 is offered. Required: B0 is accepted but discarded, stages 0–1 hold 32'h13 with valid 0, and stages 2–3 advance normally.
- **Back-pressure and saturation:** `out_ready`=0 for 6 cycles with a full chain. Required: contents frozen and `in_ready`=0. With CNT_W=2, 5 retirements leave `retire_cnt`=3.
- **Reset mid-stream:** assert `reset`=0 asynchronously between edges with valid data. Required: `out_valid` falls immediately, and everything matches the reset-state checks.
